// File: rtl/rca_signed_pipe.sv
// Segment-pipelined signed ripple-carry adder/subtractor. One SEG-bit slice is
// resolved per stage; valid/ready handshake with a single global advance.
module rca_signed_pipe #(
  parameter int N   = 32,
  parameter int SEG = 8,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int STAGES = (N / SEG < 1) ? 1 : N / SEG;
  localparam int L      = STAGES - 1;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  function automatic logic [N-1:0] sat_val(input logic neg);
    logic signed [N-1:0] lim;
    lim = neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return lim;
  endfunction

  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] b_q   [STAGES];
  logic [N-1:0] r_q   [STAGES];
  logic         cy_q  [STAGES];
  logic         vld_q [STAGES];
  logic         ovf_q;

  logic [N-1:0] a_w   [STAGES];
  logic [N-1:0] b_w   [STAGES];
  logic [N-1:0] r_w   [STAGES];
  logic         cy_w  [STAGES];
  logic [SEG:0] seg_w [STAGES];

  logic [N-1:0] a_d   [STAGES];
  logic [N-1:0] b_d   [STAGES];
  logic [N-1:0] r_d   [STAGES];
  logic         ovf_d;
  logic         cmsb_w;
  logic         adv;

  assign out_valid = vld_q[L];
  assign sum       = r_q[L];
  assign c_out     = cy_q[L];
  assign ovf       = ovf_q;
  assign adv       = ~vld_q[L] | out_ready;
  assign in_ready  = adv;

  // Stage inputs: stage 0 from the ports, later stages from the skew registers.
  always_comb begin
    a_w[0]  = a;
    b_w[0]  = sub ? ~b : b;
    cy_w[0] = c_in ^ sub;
    r_w[0]  = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_w[k]  = a_q[k-1];
      b_w[k]  = b_q[k-1];
      cy_w[k] = cy_q[k-1];
      r_w[k]  = r_q[k-1];
    end
  end

  // Operands shift down one segment per stage; result slices shift in from the top,
  // so after the last stage the result is aligned and the operand top bit is A[N-1].
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_w[k] = seg_add(a_w[k][SEG-1:0], b_w[k][SEG-1:0], cy_w[k]);
      a_d[k]   = a_w[k] >> SEG;
      b_d[k]   = b_w[k] >> SEG;
      r_d[k]   = (r_w[k] >> SEG) | (N'(seg_w[k][SEG-1:0]) << (N - SEG));
    end
    cmsb_w = a_w[L][SEG-1] ^ b_w[L][SEG-1] ^ seg_w[L][SEG-1];
    ovf_d  = cmsb_w ^ seg_w[L][SEG];
    if (SAT != 0 && ovf_d) begin
      r_d[L] = sat_val(a_w[L][SEG-1]);
    end
  end

  // Pipeline registers: all stages advance together or all hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        cy_q[k]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        r_q[k]  <= r_d[k];
        cy_q[k] <= seg_w[k][SEG];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_rca_signed_pipe.sv
// Scoreboard bench for rca_signed_pipe: wrap and saturating instances run in lockstep.
module tb_rca_signed_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic [31:0] ss;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        sub_i = 1'b0;
  logic        cin_i = 1'b0;

  logic        iready_w, ovalid_w, cout_w, ovf_w;
  logic [31:0] sum_w;
  logic        s_iready_w, s_ovalid_w, s_cout_w, s_ovf_w;
  logic [31:0] s_sum_w;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int cyc = 0;
  vec_t exp_q[$];
  int   pop_cyc[$];
  vec_t dir[10];

  rca_signed_pipe #(.N(32), .SEG(8), .SAT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready_w),
    .a(a_i), .b(b_i), .sub(sub_i), .c_in(cin_i),
    .out_valid(ovalid_w), .out_ready(out_ready),
    .sum(sum_w), .c_out(cout_w), .ovf(ovf_w)
  );

  rca_signed_pipe #(.N(32), .SEG(8), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_iready_w),
    .a(a_i), .b(b_i), .sub(sub_i), .c_in(cin_i),
    .out_valid(s_ovalid_w), .out_ready(out_ready),
    .sum(s_sum_w), .c_out(s_cout_w), .ovf(s_ovf_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic vec_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic ci);
    vec_t e;
    logic [31:0] yy;
    logic [32:0] f;
    yy = s ? ~y : y;
    f = {1'b0, x} + {1'b0, yy} + {32'd0, ci ^ s};
    e.a = x; e.b = y; e.sub = s; e.cin = ci;
    e.s = f[31:0];
    e.c = f[32];
    e.o = (x[31] == yy[31]) && (f[31] != x[31]);
    e.ss = e.o ? (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : f[31:0];
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic s,
                              input logic ci, input logic [31:0] rs, input logic [31:0] rss,
                              input logic rc, input logic ro);
    vec_t v;
    v.a = x; v.b = y; v.sub = s; v.cin = ci; v.s = rs; v.ss = rss; v.c = rc; v.o = ro;
    return v;
  endfunction

  // Monitor: pop and compare whenever a result beat is taken.
  always @(negedge clk) begin
    if (!rst && ovalid_w && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%h required=none", sum_w);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("sum", sum_w, e.s);
        chk("c_out", {31'd0, cout_w}, {31'd0, e.c});
        chk("ovf", {31'd0, ovf_w}, {31'd0, e.o});
        chk("sat_sum", s_sum_w, e.ss);
        chk("sat_valid", {31'd0, s_ovalid_w}, 32'd1);
      end
      pops++;
      pop_cyc.push_back(cyc);
    end
  end

  task automatic send(input vec_t v);
    int n;
    logic ok;
    n = 0;
    in_valid = 1'b1;
    a_i = v.a; b_i = v.b; sub_i = v.sub; cin_i = v.cin;
    do begin
      @(negedge clk);
      ok = iready_w;
      if (ok) exp_q.push_back(v);
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d required=<50", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    vec_t r;
    dir[0] = mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1);
    dir[1] = mk(32'h0000_0005, 32'h0000_0007, 1, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0);
    dir[2] = mk(32'h8000_0000, 32'h0000_0001, 1, 0, 32'h7FFF_FFFF, 32'h8000_0000, 1, 1);
    dir[3] = mk(32'h00FF_FFFF, 32'h0000_0001, 0, 0, 32'h0100_0000, 32'h0100_0000, 0, 0);
    dir[4] = mk(32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 32'h0000_0000, 32'h0000_0000, 1, 0);
    dir[5] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 0);
    dir[6] = mk(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 32'h8000_0000, 1, 1);
    dir[7] = mk(32'h0000_000A, 32'h0000_0003, 1, 1, 32'h0000_0006, 32'h0000_0006, 1, 0);
    dir[8] = mk(32'h0000_0000, 32'h0000_0000, 1, 0, 32'h0000_0000, 32'h0000_0000, 1, 0);
    dir[9] = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, ovalid_w}, 32'd0);
    chk("rst_sum", sum_w, 32'd0);
    chk("rst_c_out", {31'd0, cout_w}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_w}, 32'd0);
    chk("rst_in_ready", {31'd0, iready_w}, 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with one bubble in the middle
    for (int i = 0; i < 10; i++) begin
      send(dir[i]);
      if (i == 4) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Streaming: 16 back-to-back beats, results one per cycle
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      r = model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send(r);
    end
    drain();
    chk("stream_count", pop_cyc.size(), 16);
    if (pop_cyc.size() == 16) chk("stream_span", pop_cyc[15] - pop_cyc[0], 15);

    // Stall: fill with out_ready low, then hold a beat at the input for 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(dir[i]);
    in_valid = 1'b1;
    a_i = dir[4].a; b_i = dir[4].b; sub_i = dir[4].sub; cin_i = dir[4].cin;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, iready_w}, 32'd0);
      chk("stall_out_valid", {31'd0, ovalid_w}, 32'd1);
      chk("stall_sum", sum_w, dir[0].s);
      chk("stall_ovf", {31'd0, ovf_w}, {31'd0, dir[0].o});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(dir[4]);
    drain();

    // Reset with three beats in flight
    for (int i = 5; i < 8; i++) send(dir[i]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    p0 = pops;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, ovalid_w}, 32'd0);
    chk("mid_rst_sum", sum_w, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf_w}, 32'd0);
    chk("mid_rst_c_out", {31'd0, cout_w}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, iready_w}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_no_stale", pops - p0, 0);

    // Pipe still works after the mid-operation reset
    send(dir[9]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rca_signed_pipe.md
# rca_signed_pipe

Parametrised, segment-pipelined signed ripple-carry adder/subtractor with valid/ready handshake, signed-overflow detection and optional saturation. An N-bit operation is split into SEG-bit segments, one segment resolved per pipeline stage, so carry ripple per cycle is bounded to SEG bits. It is the adder used by the Barrett reduction datapath for wide quotient and remainder arithmetic at full clock rate.

## Interface
- N, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, segment width, i.e. bits resolved per stage; STAGES = N/SEG (derived, at least 1).
- SAT, 0, 1 = clamp SUM to the signed max/min on overflow; 0 = wrap.

Reset is synchronous and active-high. There is one clock.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  N  signed operand A.
- b  in  N  signed operand B.
- sub  in  1  0 = A+B+c_in; 1 = A−B−c_in (c_in acts as borrow).
- c_in  in  1  carry-in (add) or borrow-in (subtract).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  N  signed result.
- c_out  out  1  raw carry out of bit N−1 (in subtract, 1 = no borrow).
- ovf  out  1  signed overflow of the unsaturated result.

## Operation
- Effective operands: B' = sub ? ~b : b; carry0 = c_in ^ sub.
- Stage k (0..STAGES−1) adds segment k of A and B' plus the carry registered from stage k−1 (stage 0 uses carry0).
- Segments of A and B' not yet consumed travel forward through skew registers. Result segments already computed travel forward with them.
- The final stage also produces the carry into bit N−1 and the carry out of bit N−1.
- ovf = carry_into_msb ^ carry_out_of_msb.
- c_out = carry_out_of_msb.
- SAT=1 with ovf=1: sum = A[N−1] ? 2^(N−1) (min) : 2^(N−1)−1 (max). The sign of the original A is carried through the pipe for this.
- SAT=0, or ovf=0: sum is the wrapped N-bit result.
- ovf is reported in both SAT modes.
- Each stage holds a valid bit. There are no internal bubbles requirements; results leave in acceptance order.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv, combinational from out_ready and the last-stage valid.
- A beat is accepted when in_valid & in_ready. When adv=0 every pipeline register holds.
- Reset values: every valid bit 0, so out_valid = 0. sum = 0, c_out = 0, ovf = 0. All skew and data registers are 0. in_ready = 1 in the first cycle after reset.
- Reset asserted mid-operation discards all in-flight beats; nothing from before the reset ever appears on the output.

## Timing
- Latency: a beat accepted at edge t is presented on the output (out_valid=1) after edge t+STAGES−1, i.e. STAGES register stages in total. With STAGES=1 the result is registered once.
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, sum/c_out/ovf/out_valid are held stable and in_ready=0. On the cycle out_ready returns, the pipe advances and a new beat may be accepted in that same cycle.
- Simultaneous accept and emit in one cycle is legal and must not drop or duplicate a beat.
- in_valid=0 cycles insert bubbles, which propagate as out_valid=0.
- Critical combinational path: one SEG-bit ripple plus mux and valid logic.

## Test plan
All scenarios use N=32, SEG=8 (4 stages).
- **Overflow, wrap:** a=0x7FFFFFFF, b=1, sub=0, c_in=0, SAT=0 → 4 edges later sum=0x80000000, ovf=1, c_out=0.
- **Overflow, saturate:** same stimulus with SAT=1 → sum=0x7FFFFFFF, ovf=1.
- **Subtract:** 5−7 → sum=0xFFFFFFFE, c_out=0, ovf=0.
- **Subtract with overflow:** 0x80000000−1 → sum=0x7FFFFFFF, c_out=1, ovf=1. With SAT=1 → sum=0x80000000.
- **Cross-segment ripple:** 0x00FFFFFF+1 → sum=0x01000000. Also 0xFFFFFFFF+0 with c_in=1 → sum=0, c_out=1, ovf=0.
- **Streaming:** 16 random beats back-to-back with out_ready=1 → 16 results in order, one per cycle, all matching a reference model including ovf/c_out.
- **Stall:** pipe full, out_ready=0 for 3 cycles → in_ready=0, outputs frozen. After release, no loss or duplication, and a beat presented with in_valid during the stall is accepted only after release.
- **Reset mid-operation:** rst for 1 cycle with 3 beats in flight → next cycle out_valid=0, sum=0, ovf=0, c_out=0, in_ready=1. No stale beats emerge afterward.
